quadrature_wheel_emulator: RTL

Generates quadrature A/B signals that emulate a rotating wheel encoder, as the driving end of the encoder interface. Accepts a step command (direction, edge count), emits a Gray-coded A/B sequence at a fixed edge period, and can inject contact bounce on the switching channel. Used in hardware-in-the-loop checks of the wheel decoder and as a stimulus source on the board (switch/GPIO driven).

---
 rtl/encoder_pkg.sv | 19 +
 rtl/bounce_shaper.sv | 60 ++++++
 rtl/quadrature_wheel_emulator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared quadrature encoder definitions: FSM encoding, direction codes and
// the Gray-code phase successor tables indexed by the current {A,B}.
package encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_FINISH
    } state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // CW: 00->10->11->01->00, CCW: 00->01->11->10->00
    localparam logic [3:0][1:0] CW_NEXT  = {2'b01, 2'b11, 2'b00, 2'b10};
    localparam logic [3:0][1:0] CCW_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

endpackage

// File: rtl/bounce_shaper.sv
// Contact-bounce shaper for one quadrature channel: on trigger, the output
// alternates new/old in BOUNCE_WIDTH chunks for BOUNCE_PULSES pulses.
module bounce_shaper #(
    parameter int BOUNCE_WIDTH  = 2,
    parameter int BOUNCE_PULSES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic trig,
    input  logic force_settle,
    output logic out
);

    localparam int TOT = 2 * BOUNCE_PULSES * BOUNCE_WIDTH;
    localparam int IW  = $clog2(TOT + 1);

    logic          out_q, out_d;
    logic          active_q, active_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] half;

    assign half = idx_q / IW'(BOUNCE_WIDTH);

    // The trigger cycle already loads the new level; idx counts cycles since.
    always_comb begin
        out_d    = level;
        active_d = active_q;
        idx_d    = idx_q;
        if (force_settle) begin
            active_d = 1'b0;
            idx_d    = '0;
        end else if (trig) begin
            active_d = 1'b1;
            idx_d    = IW'(1);
        end else if (active_q) begin
            out_d = level ^ half[0];
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(TOT - 1)) begin
                active_d = 1'b0;
                idx_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= 1'b0;
            active_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            out_q    <= out_d;
            active_q <= active_d;
            idx_q    <= idx_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/quadrature_wheel_emulator.sv
// Quadrature wheel encoder emulator: emits N Gray-coded A/B edges at a
// fixed period with optional contact bounce, tracking signed position.
module quadrature_wheel_emulator
    import encoder_pkg::*;
#(
    parameter int PERIOD        = 50,
    parameter int BOUNCE_WIDTH  = 2,
    parameter int BOUNCE_PULSES = 2,
    parameter int W_STEPS       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic [W_STEPS-1:0] n_steps,
    input  logic               bounce_en,
    input  logic               abort,
    output logic               A,
    output logic               B,
    output logic               busy,
    output logic               done,
    output logic [W_STEPS-1:0] position
);

    localparam int CW = $clog2(PERIOD);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W_STEPS-1:0] left_q, left_d;
    logic [W_STEPS-1:0] pos_q, pos_d;
    logic [1:0]         phase_q, phase_d;
    logic               dir_q, dir_d;
    logic               ben_q, ben_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fire;
    logic               settle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        ben_d   = ben_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fire    = 1'b0;
        settle  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d = dir;
                    ben_d = bounce_en;
                    if (n_steps == '0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        // Counting from 1 lands edge k exactly k*PERIOD after accept.
                        state_d = ST_RUN;
                        cnt_d   = CW'(1);
                        left_d  = n_steps;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    settle  = 1'b1;
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == CW'(PERIOD - 1)) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    left_d  = left_q - W_STEPS'(1);
                    phase_d = (dir_q == DIR_CCW) ? CCW_NEXT[phase_q]
                                                 : CW_NEXT[phase_q];
                    pos_d   = (dir_q == DIR_CW) ? pos_q + W_STEPS'(1)
                                                : pos_q - W_STEPS'(1);
                    if (left_q == W_STEPS'(1)) begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (abort || cnt_q == CW'(PERIOD - 1)) begin
                    settle  = abort;
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            left_q  <= '0;
            pos_q   <= '0;
            phase_q <= 2'b00;
            dir_q   <= 1'b0;
            ben_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            ben_q   <= ben_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Only the channel that actually switches gets bounced.
    logic trig_a, trig_b;
    assign trig_a = fire & ben_q & (phase_d[1] ^ phase_q[1]);
    assign trig_b = fire & ben_q & (phase_d[0] ^ phase_q[0]);

    bounce_shaper #(
        .BOUNCE_WIDTH (BOUNCE_WIDTH),
        .BOUNCE_PULSES(BOUNCE_PULSES)
    ) u_shape_a (
        .clk         (clk),
        .rst         (reset),
        .level       (phase_d[1]),
        .trig        (trig_a),
        .force_settle(settle),
        .out         (A)
    );

    bounce_shaper #(
        .BOUNCE_WIDTH (BOUNCE_WIDTH),
        .BOUNCE_PULSES(BOUNCE_PULSES)
    ) u_shape_b (
        .clk         (clk),
        .rst         (reset),
        .level       (phase_d[0]),
        .trig        (trig_b),
        .force_settle(settle),
        .out         (B)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule
